// File: rtl/piso_serial_tx.sv
// piso_serial_tx: framed parallel-to-serial transmitter with busy/done status and a 7-seg remaining-bit count
module piso_serial_tx #(
   parameter int NBITS_REG = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit PARITY_EN = 1'b1,
   localparam int BW = $clog2(NBITS_REG + 1)
) (
   input  logic                 clk_2,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NBITS_REG-1:0] data_in,
   output logic                 serial_out,
   output logic                 busy,
   output logic                 done,
   output logic [BW-1:0]        bits_left,
   output logic [7:0]           seg
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t               state_q;
   logic [NBITS_REG-1:0] shift_q;
   logic                 parity_q;
   logic                 next_bit;
   logic [NBITS_REG-1:0] shifted;
   logic [3:0]           digit;
   assign next_bit = MSB_FIRST ? shift_q[NBITS_REG-1] : shift_q[0];
   assign shifted  = MSB_FIRST ? shift_q << 1 : shift_q >> 1;
   // Frame sequencer: START sends the first data bit, DATA drains the rest, then parity and stop
   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         serial_out <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         bits_left  <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               shift_q    <= data_in;
               parity_q   <= ^data_in;
               bits_left  <= BW'(NBITS_REG);
               serial_out <= 1'b0;
               busy       <= 1'b1;
               state_q    <= START;
            end
            START, DATA: if (state_q == START || bits_left != '0) begin
               serial_out <= next_bit;
               shift_q    <= shifted;
               bits_left  <= bits_left - 1'b1;
               state_q    <= DATA;
            end else begin
               serial_out <= PARITY_EN ? parity_q : 1'b1;
               state_q    <= PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
               serial_out <= 1'b1;
               state_q    <= STOP;
            end
            STOP: begin
               busy    <= 1'b0;
               done    <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   // Seven-segment decode of the remaining-bit count; out-of-range values show 0
   always_comb begin
      digit = 4'(bits_left);
      case (digit)
         4'd1:    seg = 8'h06;
         4'd2:    seg = 8'h5b;
         4'd3:    seg = 8'h4f;
         4'd4:    seg = 8'h66;
         4'd5:    seg = 8'h6d;
         4'd6:    seg = 8'h7d;
         4'd7:    seg = 8'h07;
         4'd8:    seg = 8'h7f;
         4'd9:    seg = 8'h6f;
         default: seg = 8'h3f;
      endcase
   end
endmodule
